// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Holds the FSM state encoding, the loss-counter width and the timer sizing helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } sup_state_t;

    localparam int LOSS_W = 8;

    // One shared timer serves every state, so it is sized for the longest terminal count.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL supervisor and the surrounding system.
// The slave modport is the supervisor; the master modport is the PLL/system side.
interface pll_lock_supervisor_if #(
    parameter int MAX_RETRIES = 3
);
    import pll_sup_pkg::*;

    localparam int RC_W = $clog2(MAX_RETRIES + 1);

    logic              locked;
    logic              clear_fault;
    logic              pll_rst;
    logic              sys_rst;
    logic              ready;
    logic              fault;
    logic [RC_W-1:0]   retry_count;
    logic [LOSS_W-1:0] loss_count;

    modport master (
        output locked, clear_fault,
        input  pll_rst, sys_rst, ready, fault, retry_count, loss_count
    );

    modport slave (
        input  locked, clear_fault,
        output pll_rst, sys_rst, ready, fault, retry_count, loss_count
    );

endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// Clears to 0 on reset so a status input reads inactive until proven otherwise.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock and only then releases the system reset.
// Retries on lock timeout, re-arms on lock loss and latches a fault after repeated failures.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 2
) (
    input logic                  refclk,
    input logic                  rst,
    pll_lock_supervisor_if.slave bus
);

    localparam int TIMER_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RC_W    = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]    RETRY_MAX    = RC_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_SAT     = '1;

    sup_state_t        state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [RC_W-1:0]    retry_reg, retry_next;
    logic [LOSS_W-1:0]  loss_reg, loss_next;
    logic               pll_rst_reg, pll_rst_next;
    logic               sys_rst_reg, sys_rst_next;
    logic               ready_reg, ready_next;
    logic               fault_reg, fault_next;
    logic               locked_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg   <= RESET_PLL;
            timer_reg   <= '0;
            retry_reg   <= '0;
            loss_reg    <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retry_reg   <= retry_next;
            loss_reg    <= loss_next;
            pll_rst_reg <= pll_rst_next;
            sys_rst_reg <= sys_rst_next;
            ready_reg   <= ready_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        unique case (state_reg)
            RESET_PLL: begin
                if (timer_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Lock is checked first so a lock arriving on the timeout cycle wins.
                if (locked_s) begin
                    state_next = STABLE;
                    timer_next = '0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    retry_next = retry_reg + 1'b1;
                    timer_next = '0;
                    state_next = (retry_reg + 1'b1 == RETRY_MAX) ? FAULT : RESET_PLL;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer_reg == STABLE_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                    retry_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = RESET_PLL;
                    timer_next = '0;
                    loss_next  = (loss_reg == LOSS_SAT) ? loss_reg : loss_reg + 1'b1;
                end
            end
            FAULT: begin
                if (bus.clear_fault) begin
                    state_next = RESET_PLL;
                    timer_next = '0;
                    retry_next = '0;
                end
            end
            default: begin
                state_next = RESET_PLL;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the transition edge.
    always_comb begin
        pll_rst_next = (state_next == RESET_PLL) || (state_next == FAULT);
        sys_rst_next = (state_next != RUN);
        ready_next   = (state_next == RUN);
        fault_next   = (state_next == FAULT);
    end

    assign bus.pll_rst     = pll_rst_reg;
    assign bus.sys_rst     = sys_rst_reg;
    assign bus.ready       = ready_reg;
    assign bus.fault       = fault_reg;
    assign bus.retry_count = retry_reg;
    assign bus.loss_count  = loss_reg;

endmodule
